// File: rtl/mul_seq_32.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier with start/busy/done handshake.
// One multiplier bit per clock through a 32-bit ripple-carry adder.

module add_rca_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign cout = w_c[32];

endmodule

module mul_seq_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] p
);

  localparam int unsigned W     = 32;
  localparam int unsigned PW    = 2 * W;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned ITERS = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W-1:0]     r_m;
  logic [PW-1:0]    r_p;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_last;
  logic [W-1:0]     w_sum;
  logic             w_cout;

  add_rca_32 u_add (
    .a    (r_p[PW-1:W]),
    .b    (r_m),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_count == CNT_W'(ITERS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = start ? S_RUN : S_IDLE;
      S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  // Datapath: carry-out of the add lands in bit 63 after the shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m     <= '0;
      r_p     <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_m     <= a;
      r_p     <= {W'(0), b};
      r_count <= '0;
    end else if (r_state == S_RUN) begin
      if (r_p[0]) begin
        r_p <= {w_cout, w_sum, r_p[W-1:1]};
      end else begin
        r_p <= {1'b0, r_p[PW-1:1]};
      end
      r_count <= CNT_W'(r_count + CNT_W'(1));
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign p    = r_p;

endmodule

// File: tb/tb_mul_seq_32.sv
// Scoreboard bench for mul_seq_32: reference model queues a*b on each accepted start,
// a monitor checks busy/done every cycle and pops/compares p on each done pulse.

module tb_mul_seq_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy;
  logic        done;
  logic [63:0] p;

  int n_checks = 0;
  int n_errors = 0;
  int n_accept = 0;
  int n_done   = 0;

  logic [63:0] exp_q[$];
  int          cnt = 0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic [63:0] exp_hold = '0;
  logic [63:0] cur_prod = '0;

  always #5 clk = ~clk;

  mul_seq_32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a_in),
    .b     (b_in),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request occupies 32 busy cycles then one done cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (cnt > 0) n_accept--;
      cnt      = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_hold = '0;
      exp_q.delete();
    end else begin
      exp_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          exp_done = 1'b1;
          exp_hold = cur_prod;
        end
      end else if (start) begin
        cur_prod = 64'(a_in) * 64'(b_in);
        exp_q.push_back(cur_prod);
        cnt = 32;
        n_accept++;
      end
      exp_busy = (cnt > 0);
    end
  end

  // Monitor
  always @(negedge clk) begin
    check("busy", 64'(busy), 64'(exp_busy));
    check("done", 64'(done), 64'(exp_done));
    if (done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        check("product", p, exp_q.pop_front());
      end
    end
    if (!exp_busy && !exp_done) check("p_hold", p, exp_hold);
  end

  task automatic do_op(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1;
    a_in  = av;
    b_in  = bv;
    @(negedge clk);
    start = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    repeat (34) @(negedge clk);
  endtask

  initial begin
    int cycles;
    int target;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_op(32'd3, 32'd5);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op(32'd0, 32'h1234_5678);
    do_op(32'h1234_5678, 32'd1);
    do_op(32'h8000_0000, 32'h8000_0000);

    // Start held through RUN: second request accepted in the DONE cycle
    @(negedge clk);
    start = 1'b1;
    a_in  = 32'd7;
    b_in  = 32'd9;
    @(negedge clk);
    a_in  = 32'd1;
    b_in  = 32'd1;
    repeat (33) @(negedge clk);
    start = 1'b0;
    repeat (36) @(negedge clk);

    // Asynchronous reset at iteration 10
    @(negedge clk);
    start = 1'b1;
    a_in  = 32'hDEAD_BEEF;
    b_in  = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_p", p, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op(32'd6, 32'd7);

    // Random back-to-back regression
    target = n_accept + 1000;
    cycles = 0;
    while (n_accept < target && cycles < 60000) begin
      @(negedge clk);
      start = ($urandom_range(0, 9) != 0);
      a_in  = $urandom;
      b_in  = $urandom;
      cycles++;
    end
    if (n_accept < target) begin
      n_checks++;
      n_errors++;
      $display("FAIL random_timeout: got %0d accepts expected %0d", n_accept, target);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(n_done), 64'(n_accept));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mul_seq_32.md
Name: mul_seq_32

Overview:
- Sequential unsigned 32x32 -> 64-bit shift-and-add multiplier for the CPU datapath.
- Sits directly downstream of the 32-bit ripple-carry adder: instantiates one add_rca_32 and consumes its sum and carry-out once per cycle.
- Takes 32 iterations, one multiplier bit per clock.
- Uses a start/busy/done handshake toward the execute-stage controller.

Parameters:
- none: width is fixed at 32 by add_rca_32; iteration count is fixed at 32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only when busy=0
- a  input  32  multiplicand, captured on the accepted start
- b  input  32  multiplier, captured on the accepted start
- busy  output  1  high while iterating
- done  output  1  single-cycle pulse; p is valid while done=1
- p  output  64  product register

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, p=0, count=0.
- Internal registers:
  - M[31:0]: multiplicand.
  - P[63:0]: product/multiplier register; p is driven directly from P.
  - count[4:0]: iteration counter.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- Accept: on a rising edge where start=1 and state is IDLE or DONE:
  - M<=a, P<={32'b0,b}, count<=0, state<=RUN.
- RUN iteration, every edge:
  - Adder inputs: add_rca_32 a=P[63:32], b=M, cin=0, giving outputs sum and cout.
  - If P[0]=1: P<={cout, sum, P[31:1]}.
  - Else: P<={1'b0, P[63:1]}.
  - The carry-out must be kept; it is bit 63 after the shift.
  - count<=count+1. When count==31 on that edge, state<=DONE.
- DONE:
  - Lasts exactly one cycle, then IDLE, unless start=1 in that cycle.
  - If start=1 in DONE, the new operation is accepted: next state is RUN and done deasserts.
- Latency:
  - Accept at edge k. busy is high after edge k.
  - 32 iterations on edges k+1..k+32.
  - done=1 and p=a*b after edge k+32.
  - Total 33 cycles from accept to the done cycle.
  - Back-to-back throughput: one result per 33 cycles.
- Result hold: p holds the final product from DONE through IDLE until the next accept. On accept it changes to {0,b}.
- start while busy=1 is ignored; M, P and count are unaffected.
- a and b are don't-care except on the accepting edge.
- Reset mid-operation: asynchronous return to IDLE with all reset values applied immediately. No partial result is retained. The first start after release behaves normally.
- Arithmetic:
  - Unsigned only.
  - The maximum product 0xFFFFFFFE00000001 fits in 64 bits, so no overflow flag is needed.
  - No intermediate sum exceeds 33 bits (sum plus cout).
- No X propagation: every register has a defined reset value, and the next-state logic has a default branch to IDLE.

Test Plan:
1. Basic product:
   - Stimulus: reset, then start with a=3, b=5.
   - Response: busy high 32 cycles; done pulses exactly once, 33 cycles after accept; p=0x000000000000000F; then busy=0, done=0, p held.
2. Maximum operands (carry path):
   - Stimulus: a=0xFFFFFFFF, b=0xFFFFFFFF.
   - Response: p=0xFFFFFFFE00000001, which exercises cout into bit 63.
3. Zero and identity edge cases:
   - a=0, b=0x12345678 -> p=0.
   - a=0x12345678, b=1 -> p=0x0000000012345678.
   - a=0x80000000, b=0x80000000 -> p=0x4000000000000000.
4. Handshake:
   - Stimulus: start a=7, b=9; hold start=1 with a=1, b=1 throughout RUN.
   - Response: result p=63, and the second request is accepted in the DONE cycle.
   - Then: done drops next cycle, busy=1, and the following done gives p=1.
5. Reset mid-operation:
   - Stimulus: start a=0xDEADBEEF, b=0x1234; assert rst_n=0 asynchronously at iteration 10.
   - Response: busy=0, done=0, p=0 immediately, before the next clock edge.
   - Then: release reset; a=6, b=7 gives p=42 with normal 33-cycle latency.
6. Random regression:
   - Stimulus: 1000 random a/b pairs issued back-to-back, including starts in DONE cycles.
   - Response: each p matches the 64-bit reference a*b; exactly one done per accepted start.
